cam_capture: RTL and testbench

Camera front-end for the ball detector. It oversamples the OV-style parallel camera bus (`apclk`, `ahref`, `avsync`, `adata`) in the system clock domain and pairs bytes into 16-bit pixels. Each pixel carries x/y coordinates and frame/line markers. The block sits between the sensor pins and the detection core, replacing raw per-byte handling with a single-cycle pixel strobe.

---
 rtl/cam_capture.sv | 158 +++++++++++++++
 tb/tb_cam_capture.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_capture.sv
`timescale 1ns/1ps
// cam_capture: oversamples an OV-style parallel camera bus and pairs bytes into 16-bit pixels with x/y and frame/line markers.
// Latency: pixel_valid and all markers are registered 2 clk after the edge that first registers the causing sensor level.
// No backpressure: each pixel is a one-cycle strobe; pixel/x/y hold until the next strobe.
module cam_capture #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        apclk,
  input  logic        ahref,
  input  logic        avsync,
  input  logic [7:0]  adata,
  output logic [15:0] pixel,
  output logic        pixel_valid,
  output logic [9:0]  x,
  output logic [8:0]  y,
  output logic        frame_start,
  output logic        line_end,
  output logic        frame_end,
  output logic        frame_err
);

  localparam logic [1:0] S_WAIT_FRAME = 2'd0;
  localparam logic [1:0] S_BLANK      = 2'd1;
  localparam logic [1:0] S_LINE       = 2'd2;

  localparam logic [9:0] H_MAX = 10'(H_PIXELS);
  localparam logic [8:0] V_MAX = 9'(V_LINES);

  logic       r_apclk_s1, r_apclk_s2, r_pclk_d;
  logic       r_ahref_s1, r_ahref_s2;
  logic       r_avsync_s1, r_avsync_s2, r_avsync_d;
  logic [7:0] r_adata_s1, r_adata_s2;

  logic [1:0] r_state;
  logic       r_phase;     // 1 when a high byte is waiting for its partner
  logic [7:0] r_hi;
  logic [9:0] r_col;       // pixels emitted on the current line, saturates at H_MAX
  logic [8:0] r_row;       // lines accepted in the current frame, saturates at V_MAX

  logic w_pclk_rise, w_vs_rise, w_vs_fall;

  // Two-flop synchronizers for every sensor pin, plus one delay stage for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_apclk_s1  <= 1'b0;
      r_apclk_s2  <= 1'b0;
      r_pclk_d    <= 1'b0;
      r_ahref_s1  <= 1'b0;
      r_ahref_s2  <= 1'b0;
      r_avsync_s1 <= 1'b0;
      r_avsync_s2 <= 1'b0;
      r_avsync_d  <= 1'b0;
      r_adata_s1  <= 8'h00;
      r_adata_s2  <= 8'h00;
    end else begin
      r_apclk_s1  <= apclk;
      r_apclk_s2  <= r_apclk_s1;
      r_pclk_d    <= r_apclk_s2;
      r_ahref_s1  <= ahref;
      r_ahref_s2  <= r_ahref_s1;
      r_avsync_s1 <= avsync;
      r_avsync_s2 <= r_avsync_s1;
      r_avsync_d  <= r_avsync_s2;
      r_adata_s1  <= adata;
      r_adata_s2  <= r_adata_s1;
    end
  end

  assign w_pclk_rise = r_apclk_s2 & ~r_pclk_d;
  assign w_vs_rise   = r_avsync_s2 & ~r_avsync_d;
  assign w_vs_fall   = ~r_avsync_s2 & r_avsync_d;

  // Frame/line FSM: pairs bytes into pixels and raises markers; a vsync rise outranks any byte sample
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_WAIT_FRAME;
      r_phase     <= 1'b0;
      r_hi        <= 8'h00;
      r_col       <= 10'd0;
      r_row       <= 9'd0;
      pixel       <= 16'h0000;
      pixel_valid <= 1'b0;
      x           <= 10'd0;
      y           <= 9'd0;
      frame_start <= 1'b0;
      line_end    <= 1'b0;
      frame_end   <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
      line_end    <= 1'b0;
      frame_end   <= 1'b0;
      case (r_state)
        S_WAIT_FRAME: begin
          if (w_vs_fall) begin
            frame_start <= 1'b1;
            frame_err   <= 1'b0;
            r_row       <= 9'd0;
            r_state     <= S_BLANK;
          end
        end
        S_BLANK, S_LINE: begin
          if (w_vs_rise) begin
            // Frame exit: partial line or wrong line count both mark the frame bad
            frame_end <= 1'b1;
            if (r_state == S_LINE || r_row != V_MAX) frame_err <= 1'b1;
            r_phase   <= 1'b0;
            r_state   <= S_WAIT_FRAME;
          end else if (w_pclk_rise) begin
            if (r_state == S_BLANK) begin
              if (r_ahref_s2) begin
                r_hi    <= r_adata_s2;
                r_phase <= 1'b1;
                r_col   <= 10'd0;
                r_state <= S_LINE;
                // Line beyond the frame height: tracked but never emitted
                if (r_row == V_MAX) frame_err <= 1'b1;
              end
            end else if (r_ahref_s2) begin
              if (!r_phase) begin
                r_hi    <= r_adata_s2;
                r_phase <= 1'b1;
              end else begin
                r_phase <= 1'b0;
                if (r_row == V_MAX) begin
                  // surplus line: swallow silently
                end else if (r_col == H_MAX) begin
                  frame_err <= 1'b1;
                end else begin
                  pixel       <= {r_hi, r_adata_s2};
                  x           <= r_col;
                  y           <= r_row;
                  pixel_valid <= 1'b1;
                  r_col       <= r_col + 10'd1;
                end
              end
            end else begin
              // ahref low: the line is over; an unpaired byte is dropped
              r_state <= S_BLANK;
              r_phase <= 1'b0;
              if (r_row != V_MAX) begin
                line_end <= 1'b1;
                r_row    <= r_row + 9'd1;
                if (r_phase) frame_err <= 1'b1;
              end
            end
          end
        end
        default: r_state <= S_WAIT_FRAME;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_capture.sv
`timescale 1ns/1ps
// tb_cam_capture: randomized camera-bus stimulus against a line/frame level reference model.
// Small frame geometry keeps the run short while exercising every boundary.
// Observed events are collected on the falling clk edge and compared per scenario.
module tb_cam_capture;
  localparam int HP = 8;
  localparam int VL = 4;

  logic        clk = 1'b0;
  logic        rst, apclk, ahref, avsync;
  logic [7:0]  adata;
  logic [15:0] pixel;
  logic        pixel_valid;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        frame_start, line_end, frame_end, frame_err;

  int checks = 0;
  int errors = 0;

  cam_capture #(.H_PIXELS(HP), .V_LINES(VL)) dut (
    .clk(clk), .rst(rst), .apclk(apclk), .ahref(ahref), .avsync(avsync), .adata(adata),
    .pixel(pixel), .pixel_valid(pixel_valid), .x(x), .y(y),
    .frame_start(frame_start), .line_end(line_end), .frame_end(frame_end), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Observed events
  logic [34:0] obs_pix[$];
  int          obs_fs, obs_le, obs_fe_n, obs_overlap;
  logic [15:0] obs_fe_vec;

  always @(negedge clk) begin
    if (pixel_valid) obs_pix.push_back({pixel, x, y});
    if (frame_start) obs_fs++;
    if (line_end) obs_le++;
    if (frame_end) begin
      obs_fe_n++;
      obs_fe_vec = {obs_fe_vec[14:0], frame_err};
    end
    if (pixel_valid && line_end) obs_overlap++;
  end

  // Reference model state
  logic [34:0] exp_pix[$];
  int          exp_fs, exp_le, exp_fe_n;
  logic [15:0] exp_fe_vec;
  int          m_row;
  logic        m_err;
  logic [7:0]  line_b[$];

  task automatic flush();
    obs_pix.delete(); exp_pix.delete();
    obs_fs = 0; obs_le = 0; obs_fe_n = 0; obs_fe_vec = '0;
    exp_fs = 0; exp_le = 0; exp_fe_n = 0; exp_fe_vec = '0;
    m_row = 0; m_err = 1'b0;
  endtask

  task automatic make_line(input int n);
    line_b.delete();
    repeat (n) line_b.push_back(8'($urandom));
  endtask

  // A complete line: pairs of bytes become pixels, bounded by width and frame height
  task automatic model_line();
    int npx;
    if (m_row >= VL) begin
      m_err = 1'b1;
      return;
    end
    npx = line_b.size() / 2;
    for (int k = 0; k < npx && k < HP; k++)
      exp_pix.push_back({line_b[2*k], line_b[2*k+1], 10'(k), 9'(m_row)});
    if (npx > HP) m_err = 1'b1;
    if ((line_b.size() % 2) != 0) m_err = 1'b1;
    exp_le++;
    m_row++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One sensor clock: data/href change at the falling edge, low phase >= 3 clk for setup
  task automatic apclk_cycle(input logic [7:0] d, input logic href);
    apclk = 1'b0; adata = d; ahref = href;
    tick($urandom_range(6, 3));
    apclk = 1'b1;
    tick($urandom_range(5, 2));
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) apclk_cycle(8'h00, 1'b0);
  endtask

  task automatic drive_line();
    for (int i = 0; i < line_b.size(); i++) apclk_cycle(line_b[i], 1'b1);
    blank(2);
  endtask

  task automatic start_frame();
    avsync = 1'b0;
    blank(3);
    m_row = 0; m_err = 1'b0;
    exp_fs++;
  endtask

  task automatic end_frame();
    avsync = 1'b1;
    blank(3);
    if (m_row != VL) m_err = 1'b1;
    exp_fe_n++;
    exp_fe_vec = {exp_fe_vec[14:0], m_err};
  endtask

  task automatic full_line();
    make_line(2 * HP);
    model_line();
    drive_line();
  endtask

  task automatic test_reset();
    rst = 1'b1; apclk = 1'b0; ahref = 1'b0; avsync = 1'b1; adata = 8'h00;
    flush();
    tick(4);
    checks++; if (pixel !== 16'h0) begin errors++; $display("FAIL reset_pixel got %h want 0000", pixel); end
    checks++; if (pixel_valid !== 1'b0) begin errors++; $display("FAIL reset_pixel_valid got %b want 0", pixel_valid); end
    checks++; if (x !== 10'd0) begin errors++; $display("FAIL reset_x got %0d want 0", x); end
    checks++; if (y !== 9'd0) begin errors++; $display("FAIL reset_y got %0d want 0", y); end
    checks++; if ({frame_start, line_end, frame_end} !== 3'b000) begin errors++; $display("FAIL reset_markers got %b want 000", {frame_start, line_end, frame_end}); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    rst = 1'b0;
    blank(3);
    checks++; if (obs_fs != 0 || obs_fe_n != 0) begin errors++; $display("FAIL reset_idle_markers got fs=%0d fe=%0d want 0 0", obs_fs, obs_fe_n); end
  endtask

  task automatic test_nominal();
    flush();
    for (int f = 0; f < 2; f++) begin
      start_frame();
      for (int l = 0; l < VL; l++) full_line();
      end_frame();
    end
    tick(10);
    checks++; if (obs_pix.size() != exp_pix.size()) begin errors++; $display("FAIL nominal_count got %0d want %0d", obs_pix.size(), exp_pix.size()); end
    for (int i = 0; i < exp_pix.size() && i < obs_pix.size(); i++) begin
      checks++; if (obs_pix[i] !== exp_pix[i]) begin errors++; $display("FAIL nominal_pixel[%0d] got %h want %h", i, obs_pix[i], exp_pix[i]); end
    end
    checks++; if (obs_le != exp_le) begin errors++; $display("FAIL nominal_line_end got %0d want %0d", obs_le, exp_le); end
    checks++; if (obs_fs != exp_fs) begin errors++; $display("FAIL nominal_frame_start got %0d want %0d", obs_fs, exp_fs); end
    checks++; if (obs_fe_n != exp_fe_n || obs_fe_vec !== exp_fe_vec) begin errors++; $display("FAIL nominal_frame_end got %0d/%b want %0d/%b", obs_fe_n, obs_fe_vec, exp_fe_n, exp_fe_vec); end
  endtask

  task automatic test_latency();
    flush();
    start_frame();
    make_line(2 * HP);
    model_line();
    apclk_cycle(line_b[0], 1'b1);
    apclk = 1'b0; adata = line_b[1];
    tick(4);
    apclk = 1'b1;
    @(posedge clk);  // E0
    @(negedge clk);
    checks++; if (pixel_valid !== 1'b0) begin errors++; $display("FAIL latency_e0 got %b want 0", pixel_valid); end
    @(posedge clk);  // E1
    @(negedge clk);
    checks++; if (pixel_valid !== 1'b0) begin errors++; $display("FAIL latency_e1 got %b want 0", pixel_valid); end
    @(posedge clk);  // E2
    @(negedge clk);
    checks++; if (pixel_valid !== 1'b1 || pixel !== {line_b[0], line_b[1]} || x !== 10'd0) begin
      errors++; $display("FAIL latency_e2 got v=%b pix=%h x=%0d want v=1 pix=%h x=0", pixel_valid, pixel, x, {line_b[0], line_b[1]});
    end
    @(posedge clk);
    @(negedge clk);
    checks++; if (pixel_valid !== 1'b0) begin errors++; $display("FAIL latency_width got %b want 0", pixel_valid); end
    tick(1);
    for (int i = 2; i < line_b.size(); i++) apclk_cycle(line_b[i], 1'b1);
    blank(2);
    for (int l = 1; l < VL; l++) full_line();
    end_frame();
    tick(10);
    checks++; if (obs_pix.size() != exp_pix.size()) begin errors++; $display("FAIL latency_count got %0d want %0d", obs_pix.size(), exp_pix.size()); end
    for (int i = 0; i < exp_pix.size() && i < obs_pix.size(); i++) begin
      checks++; if (obs_pix[i] !== exp_pix[i]) begin errors++; $display("FAIL latency_pixel[%0d] got %h want %h", i, obs_pix[i], exp_pix[i]); end
    end
    checks++; if (obs_fe_vec !== exp_fe_vec || obs_le != exp_le) begin errors++; $display("FAIL latency_frame got le=%0d err=%b want le=%0d err=%b", obs_le, obs_fe_vec, exp_le, exp_fe_vec); end
  endtask

  // Odd byte count, over-long line and too many lines, each in its own frame
  task automatic test_line_errors();
    flush();
    for (int f = 0; f < 3; f++) begin
      start_frame();
      for (int l = 0; l < VL + ((f == 2) ? 1 : 0); l++) begin
        if (f == 0 && l == 1) make_line(2 * HP + 1);
        else if (f == 1 && l == 2) make_line(2 * (HP + 3));
        else make_line(2 * HP);
        model_line();
        drive_line();
      end
      end_frame();
    end
    tick(10);
    checks++; if (obs_pix.size() != exp_pix.size()) begin errors++; $display("FAIL line_err_count got %0d want %0d", obs_pix.size(), exp_pix.size()); end
    for (int i = 0; i < exp_pix.size() && i < obs_pix.size(); i++) begin
      checks++; if (obs_pix[i] !== exp_pix[i]) begin errors++; $display("FAIL line_err_pixel[%0d] got %h want %h", i, obs_pix[i], exp_pix[i]); end
    end
    checks++; if (obs_le != exp_le) begin errors++; $display("FAIL line_err_line_end got %0d want %0d", obs_le, exp_le); end
    checks++; if (obs_fe_n != exp_fe_n || obs_fe_vec !== exp_fe_vec) begin errors++; $display("FAIL line_err_frame_err got %0d/%b want %0d/%b", obs_fe_n, obs_fe_vec, exp_fe_n, exp_fe_vec); end
  endtask

  task automatic test_early_vsync();
    int nb;
    flush();
    start_frame();
    full_line();
    full_line();
    nb = 2 * $urandom_range(1, HP - 1);
    make_line(nb);
    for (int k = 0; k < nb / 2; k++) exp_pix.push_back({line_b[2*k], line_b[2*k+1], 10'(k), 9'(m_row)});
    for (int i = 0; i < nb; i++) apclk_cycle(line_b[i], 1'b1);
    avsync = 1'b1;           // vsync rises together with href falling
    blank(3);
    exp_fe_n++;
    exp_fe_vec = {exp_fe_vec[14:0], 1'b1};
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL early_vsync_err got %b want 1", frame_err); end
    start_frame();
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL early_vsync_clear got %b want 0", frame_err); end
    for (int l = 0; l < VL; l++) full_line();
    end_frame();
    tick(10);
    checks++; if (obs_pix.size() != exp_pix.size()) begin errors++; $display("FAIL early_vsync_count got %0d want %0d", obs_pix.size(), exp_pix.size()); end
    for (int i = 0; i < exp_pix.size() && i < obs_pix.size(); i++) begin
      checks++; if (obs_pix[i] !== exp_pix[i]) begin errors++; $display("FAIL early_vsync_pixel[%0d] got %h want %h", i, obs_pix[i], exp_pix[i]); end
    end
    checks++; if (obs_le != exp_le) begin errors++; $display("FAIL early_vsync_line_end got %0d want %0d", obs_le, exp_le); end
    checks++; if (obs_fe_n != exp_fe_n || obs_fe_vec !== exp_fe_vec) begin errors++; $display("FAIL early_vsync_frame_end got %0d/%b want %0d/%b", obs_fe_n, obs_fe_vec, exp_fe_n, exp_fe_vec); end
  endtask

  task automatic test_back_to_back();
    flush();
    obs_overlap = 0;
    for (int f = 0; f < 4; f++) begin
      int nl;
      nl = $urandom_range(VL + 1, VL - 1);
      start_frame();
      for (int l = 0; l < nl; l++) begin
        make_line($urandom_range(2 * HP + 3, 1));
        model_line();
        drive_line();
      end
      end_frame();
    end
    tick(10);
    checks++; if (obs_pix.size() != exp_pix.size()) begin errors++; $display("FAIL b2b_count got %0d want %0d", obs_pix.size(), exp_pix.size()); end
    for (int i = 0; i < exp_pix.size() && i < obs_pix.size(); i++) begin
      checks++; if (obs_pix[i] !== exp_pix[i]) begin errors++; $display("FAIL b2b_pixel[%0d] got %h want %h", i, obs_pix[i], exp_pix[i]); end
    end
    checks++; if (obs_le != exp_le) begin errors++; $display("FAIL b2b_line_end got %0d want %0d", obs_le, exp_le); end
    checks++; if (obs_fs != exp_fs) begin errors++; $display("FAIL b2b_frame_start got %0d want %0d", obs_fs, exp_fs); end
    checks++; if (obs_fe_n != exp_fe_n || obs_fe_vec !== exp_fe_vec) begin errors++; $display("FAIL b2b_frame_end got %0d/%b want %0d/%b", obs_fe_n, obs_fe_vec, exp_fe_n, exp_fe_vec); end
    checks++; if (obs_overlap != 0) begin errors++; $display("FAIL b2b_overlap got %0d want 0", obs_overlap); end
  endtask

  task automatic test_reset_mid();
    flush();
    start_frame();
    full_line();
    full_line();
    make_line(2 * HP);
    for (int i = 0; i < HP; i++) apclk_cycle(line_b[i], 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if ({pixel_valid, frame_start, line_end, frame_end, frame_err} !== 5'b0 || pixel !== 16'h0 || x !== 10'd0 || y !== 9'd0) begin
      errors++; $display("FAIL reset_mid_outputs got v=%b pix=%h x=%0d y=%0d mk=%b want all 0", pixel_valid, pixel, x, y, {frame_start, line_end, frame_end, frame_err});
    end
    tick(3);
    rst = 1'b0;
    flush();
    make_line(2 * HP);
    drive_line();            // avsync still low: nothing may be captured
    avsync = 1'b1;
    blank(3);
    checks++; if (obs_pix.size() != 0 || obs_le != 0 || obs_fe_n != 0 || obs_fs != 0) begin
      errors++; $display("FAIL reset_mid_quiet got pix=%0d le=%0d fe=%0d fs=%0d want 0", obs_pix.size(), obs_le, obs_fe_n, obs_fs);
    end
    start_frame();
    for (int l = 0; l < VL; l++) full_line();
    end_frame();
    tick(10);
    checks++; if (obs_pix.size() != exp_pix.size()) begin errors++; $display("FAIL reset_mid_count got %0d want %0d", obs_pix.size(), exp_pix.size()); end
    for (int i = 0; i < exp_pix.size() && i < obs_pix.size(); i++) begin
      checks++; if (obs_pix[i] !== exp_pix[i]) begin errors++; $display("FAIL reset_mid_pixel[%0d] got %h want %h", i, obs_pix[i], exp_pix[i]); end
    end
    checks++; if (obs_fe_n != exp_fe_n || obs_fe_vec !== exp_fe_vec || obs_le != exp_le) begin
      errors++; $display("FAIL reset_mid_frame got fe=%0d/%b le=%0d want fe=%0d/%b le=%0d", obs_fe_n, obs_fe_vec, obs_le, exp_fe_n, exp_fe_vec, exp_le);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_latency();
    test_line_errors();
    test_early_vsync();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog simulation did not complete");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
